// File: rtl/demo_seq_pkg.sv
// Shared types and constants for the demo scene sequencer.
// Contents:
//   seq_state_t    - scene phase: FADE_IN, RUN, FADE_OUT
//   FADE_MAX       - fade level of full brightness
//   FADE_OUT_START - first fade level after a scene ends
package demo_seq_pkg;

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        RUN      = 2'd1,
        FADE_OUT = 2'd2
    } seq_state_t;

    localparam logic [2:0] FADE_MAX       = 3'd7;
    localparam logic [2:0] FADE_OUT_START = 3'd6;

endpackage

// File: rtl/scene_next_finder.sv
// Combinational wrap-around priority search for the next enabled scene.
// Ports:
//   cur_id  - current scene index
//   enable  - one bit per scene, set when that scene's duration is nonzero
//   next_id - first enabled index after cur_id (wrapping); cur_id if none
//   found   - high when some other scene is enabled
module scene_next_finder #(
    parameter int NUM_SCENES = 8
) (
    input  logic [$clog2(NUM_SCENES)-1:0] cur_id,
    input  logic [NUM_SCENES-1:0]         enable,
    output logic [$clog2(NUM_SCENES)-1:0] next_id,
    output logic                          found
);
    localparam int ID_W = $clog2(NUM_SCENES);

    logic [ID_W-1:0] probe;

    // Walk the offsets from farthest to nearest so the nearest enabled
    // scene is the last assignment and wins. The current scene itself is
    // never a candidate; index arithmetic wraps because NUM_SCENES is a
    // power of two.
    always_comb begin
        next_id = cur_id;
        found   = 1'b0;
        probe   = '0;
        for (int k = NUM_SCENES - 1; k >= 1; k--) begin
            probe = cur_id + ID_W'(k);
            if (enable[probe]) begin
                next_id = probe;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-level scheduler for the VGA demo effects datapath. Steps through a
// programmable table of scene durations, fading each scene in and out,
// and publishes frame counters and beat timing for the effect mux and
// audio generator.
// Ports:
//   clk, reset         - pixel clock, asynchronous active-high reset
//   frame_tick         - one-cycle pulse per frame
//   pause              - while high, frame_tick is ignored
//   skip_req/skip_ack  - request early scene end / accepted pulse
//   cfg_we/addr/dur    - duration table write port (0 disables a scene)
//   scene_id, scene_frame, global_frame - scene and frame counters
//   fade_level         - 0 black .. 7 full brightness
//   beat_tick, beat_index - beat pulse and beat number within a bar
//   running            - high while the scene is at full brightness
module demo_scene_sequencer
    import demo_seq_pkg::*;
#(
    parameter int NUM_SCENES  = 8,
    parameter int FRAME_W     = 12,
    parameter int DUR_W       = 8,
    parameter int DEFAULT_DUR = 32,
    parameter int BEAT_FRAMES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic                          pause,
    input  logic                          skip_req,
    output logic                          skip_ack,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_SCENES)-1:0] cfg_addr,
    input  logic [DUR_W-1:0]              cfg_dur,
    output logic [$clog2(NUM_SCENES)-1:0] scene_id,
    output logic [FRAME_W-1:0]            scene_frame,
    output logic [FRAME_W-1:0]            global_frame,
    output logic [2:0]                    fade_level,
    output logic                          beat_tick,
    output logic [1:0]                    beat_index,
    output logic                          running
);
    localparam int ID_W   = $clog2(NUM_SCENES);
    localparam int BEAT_W = $clog2(BEAT_FRAMES);

    seq_state_t             state, state_nxt;
    logic [DUR_W-1:0]       dur_table [NUM_SCENES];
    logic [NUM_SCENES-1:0]  scene_en;
    logic [ID_W-1:0]        next_id;
    logic                   next_found;
    logic [BEAT_W-1:0]      beat_cnt;
    logic                   tick;
    logic                   scene_done;
    logic [FRAME_W:0]       frame_plus_one;
    logic [FRAME_W-1:0]     scene_frame_inc;
    logic [ID_W-1:0]        scene_id_nxt;
    logic [FRAME_W-1:0]     scene_frame_nxt;
    logic [2:0]             fade_nxt;
    logic                   skip_ack_nxt;

    assign tick = frame_tick && !pause;

    // Duration table. The address width exactly covers NUM_SCENES, so
    // every address is in range. A tick in the same cycle as a write
    // still sees the old entry because both read registered state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SCENES; i++) begin
                dur_table[i] <= DUR_W'(DEFAULT_DUR);
            end
        end else if (cfg_we) begin
            dur_table[cfg_addr] <= cfg_dur;
        end
    end

    // A scene with a zero duration is skipped when choosing the next one.
    always_comb begin
        scene_en = '0;
        for (int i = 0; i < NUM_SCENES; i++) begin
            scene_en[i] = (dur_table[i] != '0);
        end
    end

    scene_next_finder #(
        .NUM_SCENES (NUM_SCENES)
    ) u_next_finder (
        .cur_id  (scene_id),
        .enable  (scene_en),
        .next_id (next_id),
        .found   (next_found)
    );

    // The end-of-scene test is done one bit wider so that a saturated
    // scene_frame still compares as "past the duration", and ">=" covers
    // entries rewritten below the current frame count.
    assign frame_plus_one  = {1'b0, scene_frame} + (FRAME_W + 1)'(1);
    assign scene_done      = frame_plus_one >= (FRAME_W + 1)'(dur_table[scene_id]);
    assign scene_frame_inc = (&scene_frame) ? scene_frame : scene_frame + FRAME_W'(1);

    // Scene phase next-state logic; only a tick moves anything.
    always_comb begin
        state_nxt       = state;
        scene_id_nxt    = scene_id;
        scene_frame_nxt = scene_frame;
        fade_nxt        = fade_level;
        skip_ack_nxt    = 1'b0;
        if (tick) begin
            case (state)
                FADE_IN: begin
                    fade_nxt        = fade_level + 3'd1;
                    scene_frame_nxt = scene_frame_inc;
                    if (fade_level + 3'd1 == FADE_MAX) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    scene_frame_nxt = scene_frame_inc;
                    if (skip_req || scene_done) begin
                        state_nxt    = FADE_OUT;
                        fade_nxt     = FADE_OUT_START;
                        skip_ack_nxt = skip_req;
                    end
                end
                FADE_OUT: begin
                    if (fade_level == 3'd0) begin
                        state_nxt       = FADE_IN;
                        scene_frame_nxt = '0;
                        if (next_found) begin
                            scene_id_nxt = next_id;
                        end
                    end else begin
                        fade_nxt        = fade_level - 3'd1;
                        scene_frame_nxt = scene_frame_inc;
                    end
                end
                default: begin
                    state_nxt = FADE_IN;
                end
            endcase
        end
    end

    // State and output registers; the beat counter runs on every tick
    // regardless of scene phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FADE_IN;
            scene_id     <= '0;
            scene_frame  <= '0;
            global_frame <= '0;
            fade_level   <= '0;
            beat_cnt     <= '0;
            beat_tick    <= 1'b0;
            beat_index   <= '0;
            skip_ack     <= 1'b0;
            running      <= 1'b0;
        end else begin
            state       <= state_nxt;
            scene_id    <= scene_id_nxt;
            scene_frame <= scene_frame_nxt;
            fade_level  <= fade_nxt;
            skip_ack    <= skip_ack_nxt;
            running     <= (state_nxt == RUN);
            beat_tick   <= 1'b0;
            if (tick) begin
                global_frame <= global_frame + FRAME_W'(1);
                if (beat_cnt == BEAT_W'(BEAT_FRAMES - 1)) begin
                    beat_cnt   <= '0;
                    beat_tick  <= 1'b1;
                    beat_index <= beat_index + 2'd1;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Self-checking bench for demo_scene_sequencer: a frame-level reference
// model compared every cycle, directed scenario checks against literal
// values, and a randomized soak.
module tb_demo_scene_sequencer;

    localparam int NS    = 8;
    localparam int DDUR  = 32;
    localparam int BEAT  = 16;
    localparam int FWRAP = 4096;

    localparam int M_UP   = 0;
    localparam int M_SHOW = 1;
    localparam int M_DOWN = 2;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        pause;
    logic        skip_req;
    logic        skip_ack;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_dur;
    logic [2:0]  scene_id;
    logic [11:0] scene_frame;
    logic [11:0] global_frame;
    logic [2:0]  fade_level;
    logic        beat_tick;
    logic [1:0]  beat_index;
    logic        running;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    demo_scene_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .pause        (pause),
        .skip_req     (skip_req),
        .skip_ack     (skip_ack),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_dur      (cfg_dur),
        .scene_id     (scene_id),
        .scene_frame  (scene_frame),
        .global_frame (global_frame),
        .fade_level   (fade_level),
        .beat_tick    (beat_tick),
        .beat_index   (beat_index),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per frame-level state, advanced per tick.
    typedef struct packed {
        int scene;
        int sframe;
        int ticks;
        int fade;
        int mode;
        int btick;
        int ack;
    } model_t;

    model_t mdl;
    int     m_dur [NS];

    function automatic int next_scene(input int cur);
        for (int k = 1; k < NS; k++) begin
            if (m_dur[(cur + k) % NS] != 0) return (cur + k) % NS;
        end
        return cur;
    endfunction

    function automatic model_t model_step(input model_t m, input logic tk, input logic sk);
        model_t n = m;
        int     sf;
        n.btick = 0;
        n.ack   = 0;
        if (tk) begin
            n.ticks = m.ticks + 1;
            n.btick = (n.ticks % BEAT == 0) ? 1 : 0;
            sf = (m.sframe < FWRAP - 1) ? m.sframe + 1 : FWRAP - 1;
            if (m.mode == M_UP) begin
                n.fade   = m.fade + 1;
                n.sframe = sf;
                if (n.fade == 7) n.mode = M_SHOW;
            end else if (m.mode == M_SHOW) begin
                n.sframe = sf;
                if (sk || (m.sframe + 1 >= m_dur[m.scene])) begin
                    n.mode = M_DOWN;
                    n.fade = 6;
                    n.ack  = sk ? 1 : 0;
                end
            end else begin
                if (m.fade == 0) begin
                    n.scene  = next_scene(m.scene);
                    n.sframe = 0;
                    n.mode   = M_UP;
                end else begin
                    n.fade   = m.fade - 1;
                    n.sframe = sf;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl <= '0;
            for (int i = 0; i < NS; i++) m_dur[i] <= DDUR;
        end else begin
            mdl <= model_step(mdl, frame_tick && !pause, skip_req);
            if (cfg_we) m_dur[cfg_addr] <= 32'(cfg_dur);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, on the falling edge, the DUT must match the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("m_scene_id",     32'(scene_id),     mdl.scene);
            checkOutput("m_scene_frame",  32'(scene_frame),  mdl.sframe);
            checkOutput("m_global_frame", 32'(global_frame), mdl.ticks % FWRAP);
            checkOutput("m_fade_level",   32'(fade_level),   mdl.fade);
            checkOutput("m_beat_tick",    32'(beat_tick),    mdl.btick);
            checkOutput("m_beat_index",   32'(beat_index),   (mdl.ticks / BEAT) % 4);
            checkOutput("m_skip_ack",     32'(skip_ack),     mdl.ack);
            checkOutput("m_running",      32'(running),      (mdl.mode == M_SHOW) ? 1 : 0);
        end
    end

    task automatic applyStimulus(input logic ft, input logic ps, input logic sk,
                                 input logic we, input int addr, input int dur);
        @(posedge clk);
        #2;
        frame_tick = ft;
        pause      = ps;
        skip_req   = sk;
        cfg_we     = we;
        cfg_addr   = 3'(addr);
        cfg_dur    = 8'(dur);
    endtask

    task automatic tickOnce(input logic sk);
        applyStimulus(1'b1, 1'b0, sk, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, sk, 1'b0, 0, 0);
    endtask

    task automatic cfgWrite(input int addr, input int dur);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, addr, dur);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        reset      = 1'b1;
        frame_tick = 1'b0;
        pause      = 1'b0;
        skip_req   = 1'b0;
        cfg_we     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        pause      = 1'b0;
        skip_req   = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_dur    = '0;
        repeat (3) @(posedge clk);
        #2;
        checking = 1'b1;
        checkOutput("rst_scene_id", 32'(scene_id), 0);
        checkOutput("rst_fade", 32'(fade_level), 0);
        checkOutput("rst_running", 32'(running), 0);
        checkOutput("rst_global", 32'(global_frame), 0);
        reset = 1'b0;

        // Default durations: full fade-in, run, fade-out, advance.
        $display("[TB] default scene cycle");
        for (int i = 1; i <= 39; i++) begin
            tickOnce(1'b0);
            if (i <= 7) checkOutput("fade_ramp", 32'(fade_level), i);
            if (i == 7) begin
                checkOutput("run_after_fade", 32'(running), 1);
                checkOutput("frame_after_fade", 32'(scene_frame), 7);
            end
            if (i == 16) begin
                checkOutput("beat_tick_16", 32'(beat_tick), 1);
                checkOutput("beat_index_16", 32'(beat_index), 1);
            end
            if (i == 32) begin
                checkOutput("fade_out_start", 32'(fade_level), 6);
                checkOutput("run_drop", 32'(running), 0);
            end
            if (i == 38) checkOutput("fade_out_end", 32'(fade_level), 0);
            if (i == 39) begin
                checkOutput("adv_scene", 32'(scene_id), 1);
                checkOutput("adv_frame", 32'(scene_frame), 0);
                checkOutput("adv_global", 32'(global_frame), 39);
            end
        end

        // Skip request held from tick 10.
        $display("[TB] skip request");
        doReset();
        for (int i = 1; i <= 17; i++) begin
            tickOnce(i >= 10);
            if (i == 10) begin
                checkOutput("skip_ack_pulse", 32'(skip_ack), 1);
                checkOutput("skip_fade", 32'(fade_level), 6);
            end
            if (i == 11) checkOutput("skip_ack_once", 32'(skip_ack), 0);
            if (i == 17) checkOutput("skip_adv_scene", 32'(scene_id), 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Only scene 0 enabled: it repeats.
        $display("[TB] single enabled scene");
        doReset();
        for (int a = 1; a < NS; a++) cfgWrite(a, 0);
        for (int i = 1; i <= 39; i++) tickOnce(1'b0);
        checkOutput("solo_scene", 32'(scene_id), 0);
        checkOutput("solo_frame", 32'(scene_frame), 0);
        checkOutput("solo_running", 32'(running), 0);

        // Pause freezes everything.
        $display("[TB] pause");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        end
        checkOutput("pause_global", 32'(global_frame), 0);
        checkOutput("pause_fade", 32'(fade_level), 0);
        for (int i = 1; i <= 16; i++) tickOnce(1'b0);
        checkOutput("pause_beat_tick", 32'(beat_tick), 1);
        checkOutput("pause_beat_index", 32'(beat_index), 1);
        checkOutput("pause_global16", 32'(global_frame), 16);

        // Reset in the middle of scene 2's fade-out restores the table.
        $display("[TB] reset mid fade-out");
        doReset();
        cfgWrite(0, 8);
        cfgWrite(1, 8);
        for (int i = 1; i <= 65; i++) begin
            tickOnce(1'b0);
            if (i == 15) checkOutput("short_scene1", 32'(scene_id), 1);
            if (i == 30) checkOutput("short_scene2", 32'(scene_id), 2);
        end
        checkOutput("pre_rst_scene", 32'(scene_id), 2);
        checkOutput("pre_rst_fade", 32'(fade_level), 3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_scene", 32'(scene_id), 0);
        checkOutput("async_rst_fade", 32'(fade_level), 0);
        checkOutput("async_rst_global", 32'(global_frame), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) tickOnce(1'b0);
        checkOutput("table_restored", 32'(running), 1);

        // Randomized soak, then a dense-tick stretch that wraps global_frame.
        $display("[TB] random soak");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
                          ($urandom % 20) == 0, int'($urandom % NS),
                          (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, 40)));
        end
        for (int i = 0; i < 4200; i++) begin
            applyStimulus(1'b1, ($urandom % 16) == 0, ($urandom % 10) == 0,
                          ($urandom % 30) == 0, int'($urandom % NS),
                          (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, 60)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        checking = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
